// File: rtl/march_sequencer_if.sv
// Bundle between the March C- sequencer, its address generator and the memory under test.
interface march_sequencer_if #(
  parameter int AD_W = 4,
  parameter int DW   = 8
) ();
  logic            start;
  logic [AD_W-1:0] ag_addr;
  logic            ag_carry;
  logic [DW-1:0]   mem_rdata;
  logic            ag_reset;
  logic            ag_preset;
  logic            ag_en;
  logic            ag_up_down;
  logic            mem_we;
  logic            mem_re;
  logic [DW-1:0]   mem_wdata;
  logic            busy;
  logic            done;
  logic            fail;
  logic [AD_W-1:0] fail_addr;
  logic [DW-1:0]   fail_data;

  modport master (
    input  start, ag_addr, ag_carry, mem_rdata,
    output ag_reset, ag_preset, ag_en, ag_up_down, mem_we, mem_re, mem_wdata,
           busy, done, fail, fail_addr, fail_data
  );

  modport slave (
    output start, ag_addr, ag_carry, mem_rdata,
    input  ag_reset, ag_preset, ag_en, ag_up_down, mem_we, mem_re, mem_wdata,
           busy, done, fail, fail_addr, fail_data
  );
endinterface

// File: rtl/march_sequencer.sv
// March C- BIST controller: steps six elements over an external address generator,
// checks read data against the expected background and latches the first failure.
module march_sequencer #(
  parameter int AD_W         = 4,
  parameter int DW           = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input logic               clk,
  input logic               reset,
  march_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]      state, state_nxt;
  logic [2:0]      elem, elem_nxt;
  logic            fail_q;
  logic [AD_W-1:0] fail_addr_q;
  logic [DW-1:0]   fail_data_q;
  logic            active, down, exp_bit, bg, mismatch, start_acc, capture;

  // elem 3,4 are the descending elements; exp/bg follow the March C- table
  assign active    = (state == S_SETUP) || (state == S_READ) || (state == S_CHECK) ||
                     (state == S_WRITE) || (state == S_NEXT);
  assign down      = (elem == 3'd3) || (elem == 3'd4);
  assign exp_bit   = (elem == 3'd2) || (elem == 3'd4);
  assign bg        = (elem == 3'd1) || (elem == 3'd3);
  assign mismatch  = bus.mem_rdata != {DW{exp_bit}};
  assign start_acc = (state == S_IDLE) && bus.start;
  assign capture   = (state == S_CHECK) && mismatch && !fail_q;

  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    case (state)
      S_IDLE:  if (bus.start) begin
                 state_nxt = S_SETUP;
                 elem_nxt  = 3'd0;
               end
      S_SETUP: state_nxt = (elem == 3'd0) ? S_WRITE : S_READ;
      S_READ:  state_nxt = S_CHECK;
      S_CHECK: begin
        if ((STOP_ON_FAIL != 0) && mismatch) state_nxt = S_DONE;
        else if (elem == 3'd5)               state_nxt = S_NEXT;
        else                                 state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = S_NEXT;
      S_NEXT: begin
        if (!bus.ag_carry)      state_nxt = (elem == 3'd0) ? S_WRITE : S_READ;
        else if (elem == 3'd5)  state_nxt = S_DONE;
        else begin
          state_nxt = S_SETUP;
          elem_nxt  = elem + 3'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      elem        <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
      if (start_acc) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (capture) begin
        fail_q      <= 1'b1;
        fail_addr_q <= bus.ag_addr;
        fail_data_q <= bus.mem_rdata;
      end
    end
  end

  // direction is held for the whole element so the generator's carry means max/zero
  assign bus.ag_reset   = (state == S_SETUP) && !down;
  assign bus.ag_preset  = (state == S_SETUP) && down;
  assign bus.ag_en      = (state == S_NEXT);
  assign bus.ag_up_down = active && !down;
  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_re     = (state == S_READ);
  assign bus.mem_wdata  = (state == S_WRITE) ? {DW{bg}} : '0;
  assign bus.busy       = active;
  assign bus.done       = (state == S_DONE);
  assign bus.fail       = fail_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_data  = fail_data_q;
endmodule

// File: tb/tb_march_sequencer.sv
// Runs two sequencers (run-to-end and stop-on-fail) side by side, each on its own
// address generator and 16x8 memory model with an optional stuck-at-1 on bit 3 of address 5.
module tb_march_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic fault_en = 1'b0;
  logic mon_clr = 1'b0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    march_sequencer_if #(.AD_W(4), .DW(8)) bus ();
    march_sequencer #(.AD_W(4), .DW(8), .STOP_ON_FAIL(g)) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );

    logic [3:0]  ag_q;
    logic [7:0]  mem [16];
    logic [7:0]  rd_q;
    logic [28:0] outs;
    int n_re, n_we, seg, fail_seg, e3_re, e3_wff, e3_bad;
    logic fail_seen, e3_pre;
    logic [3:0] e3_exp, e3_carry_addr;

    assign bus.start     = start;
    assign bus.ag_addr   = ag_q;
    assign bus.ag_carry  = bus.ag_up_down ? (ag_q == 4'hF) : (ag_q == 4'h0);
    assign bus.mem_rdata = rd_q;
    assign outs = {bus.ag_reset, bus.ag_preset, bus.ag_en, bus.ag_up_down, bus.mem_we,
                   bus.mem_re, bus.mem_wdata, bus.busy, bus.done, bus.fail,
                   bus.fail_addr, bus.fail_data};

    always @(posedge clk) begin
      if (reset)              ag_q <= 4'h0;
      else if (bus.ag_reset)  ag_q <= 4'h0;
      else if (bus.ag_preset) ag_q <= 4'hF;
      else if (bus.ag_en)     ag_q <= bus.ag_up_down ? ag_q + 4'd1 : ag_q - 4'd1;
      if (bus.mem_we) mem[ag_q] <= bus.mem_wdata;
      if (bus.mem_re) rd_q <= mem[ag_q] | ((fault_en && ag_q == 4'd5) ? 8'h08 : 8'h00);
    end

    // seg counts element setups: seg 2 is elem 1, seg 4 is elem 3
    always @(posedge clk) begin
      if (mon_clr) begin
        n_re <= 0; n_we <= 0; seg <= 0; fail_seg <= -1; fail_seen <= 1'b0;
        e3_re <= 0; e3_wff <= 0; e3_bad <= 0; e3_pre <= 1'b0;
        e3_exp <= 4'hF; e3_carry_addr <= 4'hA;
      end else begin
        if (bus.mem_re) n_re <= n_re + 1;
        if (bus.mem_we) n_we <= n_we + 1;
        if (bus.ag_reset || bus.ag_preset) seg <= seg + 1;
        if (bus.ag_preset && seg == 3) e3_pre <= 1'b1;
        if (!fail_seen && bus.fail) begin
          fail_seen <= 1'b1;
          fail_seg  <= seg;
        end
        if (seg == 4) begin
          if (bus.mem_re) begin
            if (ag_q != e3_exp) e3_bad <= e3_bad + 1;
            e3_exp <= e3_exp - 4'd1;
            e3_re  <= e3_re + 1;
          end
          if (bus.mem_we && bus.mem_wdata == 8'hFF) e3_wff <= e3_wff + 1;
          if ((bus.mem_re || bus.mem_we || bus.ag_en) && bus.ag_up_down) e3_bad <= e3_bad + 1;
          if (bus.ag_en && bus.ag_carry) e3_carry_addr <= ag_q;
        end
      end
    end
  end

  int lat0, lat1, busy_bad0, busy_bad1;

  // start one test on both instances; latency counted in cycles from the start edge
  task automatic run(input logic f, input int pulse_at);
    int k;
    @(negedge clk);
    fault_en = f;
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    start = 1'b1;
    lat0 = 0; lat1 = 0; busy_bad0 = 0; busy_bad1 = 0;
    k = 0;
    while ((lat0 == 0 || lat1 == 0) && k < 1000) begin
      @(negedge clk);
      k++;
      start = (pulse_at != 0 && k == pulse_at);
      if (lat0 == 0) begin
        if (inst[0].bus.done) lat0 = k;
        else if (!inst[0].bus.busy) busy_bad0++;
      end
      if (lat1 == 0) begin
        if (inst[1].bus.done) lat1 = k;
        else if (!inst[1].bus.busy) busy_bad1++;
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (inst[0].outs !== 29'd0) $display("FAIL reset_outs0 got %h want 0", inst[0].outs);
    else passes++;
    checks++;
    if (inst[1].outs !== 29'd0) $display("FAIL reset_outs1 got %h want 0", inst[1].outs);
    else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    run(1'b0, 0);
    checks++;
    if (lat0 !== 343) $display("FAIL clean_latency0 got %0d want 343", lat0); else passes++;
    checks++;
    if (lat1 !== 343) $display("FAIL clean_latency1 got %0d want 343", lat1); else passes++;
    checks++;
    if (busy_bad0 !== 0) $display("FAIL clean_busy got %0d low cycles want 0", busy_bad0); else passes++;
    checks++;
    if (inst[0].bus.fail !== 1'b0 || inst[1].bus.fail !== 1'b0)
      $display("FAIL clean_fail got %b%b want 00", inst[0].bus.fail, inst[1].bus.fail);
    else passes++;
    checks++;
    if (inst[0].n_re !== 80 || inst[0].n_we !== 80)
      $display("FAIL clean_access got re=%0d we=%0d want 80/80", inst[0].n_re, inst[0].n_we);
    else passes++;
    checks++;
    if (inst[0].bus.busy !== 1'b0 || inst[0].bus.done !== 1'b0)
      $display("FAIL clean_idle got busy=%b done=%b want 0/0", inst[0].bus.busy, inst[0].bus.done);
    else passes++;
  endtask

  task automatic test_elem3_trace();
    run(1'b0, 0);
    checks++;
    if (inst[0].e3_pre !== 1'b1) $display("FAIL e3_preset got %b want 1", inst[0].e3_pre); else passes++;
    checks++;
    if (inst[0].e3_re !== 16) $display("FAIL e3_reads got %0d want 16", inst[0].e3_re); else passes++;
    checks++;
    if (inst[0].e3_wff !== 16) $display("FAIL e3_writes_ff got %0d want 16", inst[0].e3_wff); else passes++;
    checks++;
    if (inst[0].e3_bad !== 0) $display("FAIL e3_order_dir got %0d errors want 0", inst[0].e3_bad); else passes++;
    checks++;
    if (inst[0].e3_carry_addr !== 4'h0)
      $display("FAIL e3_carry_addr got %0d want 0", inst[0].e3_carry_addr);
    else passes++;
  endtask

  task automatic test_stuck_fault();
    run(1'b1, 0);
    checks++;
    if (lat0 !== 343) $display("FAIL fault_latency0 got %0d want 343", lat0); else passes++;
    checks++;
    if (inst[0].bus.fail !== 1'b1 || inst[0].bus.fail_addr !== 4'd5 || inst[0].bus.fail_data !== 8'h08)
      $display("FAIL fault_capture0 got fail=%b addr=%0d data=%h want 1/5/08",
               inst[0].bus.fail, inst[0].bus.fail_addr, inst[0].bus.fail_data);
    else passes++;
    checks++;
    if (inst[0].fail_seg !== 2) $display("FAIL fault_elem got seg %0d want 2", inst[0].fail_seg); else passes++;
    checks++;
    if (lat1 !== 57) $display("FAIL stop_latency got %0d want 57", lat1); else passes++;
    checks++;
    if (inst[1].bus.fail !== 1'b1 || inst[1].bus.fail_addr !== 4'd5 || inst[1].bus.fail_data !== 8'h08)
      $display("FAIL stop_capture got fail=%b addr=%0d data=%h want 1/5/08",
               inst[1].bus.fail, inst[1].bus.fail_addr, inst[1].bus.fail_data);
    else passes++;
    checks++;
    if (inst[1].n_re !== 6 || inst[1].n_we !== 21)
      $display("FAIL stop_access got re=%0d we=%0d want 6/21", inst[1].n_re, inst[1].n_we);
    else passes++;
  endtask

  task automatic test_back_to_back();
    run(1'b0, 100);
    checks++;
    if (lat0 !== 343) $display("FAIL b2b_latency got %0d want 343", lat0); else passes++;
    checks++;
    if (busy_bad0 !== 0) $display("FAIL b2b_busy got %0d low cycles want 0", busy_bad0); else passes++;
    checks++;
    if (inst[0].bus.fail !== 1'b0 || inst[0].bus.fail_addr !== 4'd0 || inst[0].bus.fail_data !== 8'h00)
      $display("FAIL b2b_fail_cleared got fail=%b addr=%0d data=%h want 0/0/00",
               inst[0].bus.fail, inst[0].bus.fail_addr, inst[0].bus.fail_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (inst[0].seg != 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (inst[0].seg !== 3) $display("FAIL mid_reach_elem2 got seg %0d want 3", inst[0].seg); else passes++;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (inst[0].outs !== 29'd0) $display("FAIL mid_reset_outs got %h want 0", inst[0].outs); else passes++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (inst[0].bus.busy !== 1'b0 || inst[0].bus.done !== 1'b0)
      $display("FAIL mid_stays_idle got busy=%b done=%b want 0/0", inst[0].bus.busy, inst[0].bus.done);
    else passes++;
    run(1'b0, 0);
    checks++;
    if (lat0 !== 343 || inst[0].bus.fail !== 1'b0)
      $display("FAIL mid_rerun got lat=%0d fail=%b want 343/0", lat0, inst[0].bus.fail);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_elem3_trace();
    test_stuck_fault();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
